// File: rtl/regfile_pkg.sv
// Shared register-file constants and the index-to-write-enable mapping.
// r0 lives in the MSB of the one-hot enable; r7 lives in bit 0.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned REG_COUNT  = 8;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_COUNT-1:0]  reg_wen_t;

  localparam reg_wen_t REG_R0_BIT = 8'b1000_0000;

  function automatic reg_wen_t reg_onehot(input reg_addr_t idx);
    return REG_R0_BIT >> idx;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester/arbiter/register-file bus for regfile_write_arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface regfile_write_arbiter_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 3
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          hold;
  logic [NUM_REQ-1:0]            gnt;
  reg_wen_t                      wr_en;
  reg_addr_t                     wr_addr;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic                          busy;

  modport master (
    output req, req_addr, req_data, hold,
    input  gnt, wr_en, wr_addr, wr_data, busy
  );

  modport slave (
    input  req, req_addr, req_data, hold,
    output gnt, wr_en, wr_addr, wr_data, busy
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of eligible searching
// upward from ptr, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               valid
);

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (!valid && eligible[k] && (k == (32'(ptr) + i) % NUM_REQ)) begin
          winner = PTR_W'(k);
          valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file's single write port.
// Build option REGFILE_R0_ZERO_EN: grant r0 writes but suppress their wr_en.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 3
) (
  input logic                    clock,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  reg_wen_t              wr_en_q, wr_en_d;
  reg_addr_t             wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;

  logic [NUM_REQ-1:0]    eligible;
  logic [PTR_W-1:0]      winner;
  logic                  win_valid;
  reg_addr_t             sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // The requester holding the current grant still shows req this cycle.
  assign eligible = bus.req & ~gnt_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .winner   (winner),
    .valid    (win_valid)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (winner == PTR_W'(k)) begin
        sel_addr = bus.req_addr[k*REG_ADDR_W +: REG_ADDR_W];
        sel_data = bus.req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    gnt_d     = '0;
    wr_en_d   = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ptr_d     = ptr_q;
    if (!bus.hold && win_valid) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (winner == PTR_W'(k)) gnt_d[k] = 1'b1;
      end
      wr_addr_d = sel_addr;
      wr_data_d = sel_data;
`ifdef REGFILE_R0_ZERO_EN
      wr_en_d   = (sel_addr == '0) ? '0 : reg_onehot(sel_addr);
`else
      wr_en_d   = reg_onehot(sel_addr);
`endif
      ptr_d     = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt_q     <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ptr_q     <= '0;
    end else begin
      gnt_q     <= gnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = |gnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus a
// randomized run compared against a behavioural round-robin model.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned NR = 3;
`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  regfile_write_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  regfile_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Expected write enable: register i is bit (7 - i); r0 optionally never written.
  function automatic logic [7:0] exp_wen(input int a);
    if (R0_ZERO && a == 0) return 8'h00;
    return 8'(1 << (7 - a));
  endfunction

  task automatic set_req(input int k, input logic r, input logic [2:0] a, input logic [7:0] d);
    bus.req[k]              = r;
    bus.req_addr[3*k +: 3]  = a;
    bus.req_data[DW*k +: DW] = d;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    for (int k = 0; k < NR; k++) set_req(k, 1'b1, 3'(k + 1), 8'(8'h10 * (k + 1)));
    repeat (5) begin
      tick();
      checks++;
      if (bus.gnt !== 3'b000 || bus.wr_en !== 8'h00 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: gnt=%b wr_en=%b busy=%b expected 000/00000000/0", bus.gnt, bus.wr_en, bus.busy);
      end
    end
    checks++;
    if (bus.wr_addr !== 3'd0 || bus.wr_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_addr_data: wr_addr=%0d wr_data=%h expected 0/00", bus.wr_addr, bus.wr_data);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.gnt !== 3'b001 || bus.wr_en !== exp_wen(1) || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: gnt=%b wr_en=%b busy=%b expected 001/%b/1", bus.gnt, bus.wr_en, bus.busy, exp_wen(1));
    end
    bus.req = '0;
    tick();
    checks++;
    if (bus.gnt !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: gnt=%b expected 000", bus.gnt);
    end
  endtask

  task automatic test_single();
    int grants;
    set_req(1, 1'b1, 3'd5, 8'hA5);
    tick();
    checks++;
    if (bus.gnt !== 3'b010 || bus.wr_en !== 8'b0000_0100 || bus.wr_addr !== 3'd5 || bus.wr_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_write: gnt=%b wr_en=%b addr=%0d data=%h expected 010/00000100/5/a5", bus.gnt, bus.wr_en, bus.wr_addr, bus.wr_data);
    end
    bus.req[1] = 1'b0;
    grants = 1;
    repeat (4) begin
      tick();
      if (bus.gnt !== 3'b000) grants++;
    end
    checks++;
    if (grants != 1) begin
      errors++;
      $display("FAIL single_count: grants=%0d expected 1", grants);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] eg [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    int         ea [3] = '{1, 5, 6};
    int         ed [3] = '{8'h11, 8'h22, 8'h33};
    int         w;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < NR; k++) set_req(k, 1'b1, 3'(ea[k]), 8'(ed[k]));
    for (int i = 0; i < 5; i++) begin
      tick();
      w = (eg[i] == 3'b001) ? 0 : (eg[i] == 3'b010) ? 1 : 2;
      checks++;
      if (bus.gnt !== eg[i] || bus.wr_en !== exp_wen(ea[w]) || bus.wr_addr !== 3'(ea[w]) || bus.wr_data !== 8'(ed[w])) begin
        errors++;
        $display("FAIL rr_seq%0d: gnt=%b wr_en=%b addr=%0d data=%h expected %b/%b/%0d/%h",
                 i, bus.gnt, bus.wr_en, bus.wr_addr, bus.wr_data, eg[i], exp_wen(ea[w]), ea[w], 8'(ed[w]));
      end
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_hold();
    bus.hold = 1'b1;
    set_req(2, 1'b1, 3'd7, 8'hC3);
    repeat (4) begin
      tick();
      checks++;
      if (bus.gnt !== 3'b000 || bus.wr_en !== 8'h00 || bus.wr_addr !== 3'd5 || bus.wr_data !== 8'h22) begin
        errors++;
        $display("FAIL hold_stall: gnt=%b wr_en=%b addr=%0d data=%h expected 000/00000000/5/22", bus.gnt, bus.wr_en, bus.wr_addr, bus.wr_data);
      end
    end
    bus.hold = 1'b0;
    tick();
    checks++;
    if (bus.gnt !== 3'b100 || bus.wr_en !== 8'b0000_0001 || bus.wr_data !== 8'hC3) begin
      errors++;
      $display("FAIL hold_release: gnt=%b wr_en=%b data=%h expected 100/00000001/c3", bus.gnt, bus.wr_en, bus.wr_data);
    end
    bus.req[2] = 1'b0;
    tick();
  endtask

  task automatic test_r0();
    set_req(0, 1'b1, 3'd0, 8'h3C);
    tick();
    checks++;
    if (bus.gnt !== 3'b001 || bus.wr_en !== exp_wen(0) || bus.wr_addr !== 3'd0 || bus.wr_data !== 8'h3C) begin
      errors++;
      $display("FAIL r0_write: gnt=%b wr_en=%b addr=%0d data=%h expected 001/%b/0/3c", bus.gnt, bus.wr_en, bus.wr_addr, bus.wr_data, exp_wen(0));
    end
    bus.req[0] = 1'b0;
    tick();
  endtask

  task automatic test_reset_inflight();
    set_req(1, 1'b1, 3'd3, 8'h5A);
    @(posedge clock);
    #1;
    checks++;
    if (bus.gnt !== 3'b010) begin
      errors++;
      $display("FAIL inflight_grant: gnt=%b expected 010", bus.gnt);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.gnt !== 3'b000 || bus.wr_en !== 8'h00 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL inflight_async_clear: gnt=%b wr_en=%b busy=%b expected 000/00000000/0", bus.gnt, bus.wr_en, bus.busy);
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    tick();
    checks++;
    if (bus.gnt !== 3'b010 || bus.wr_en !== 8'b0001_0000 || bus.wr_data !== 8'h5A) begin
      errors++;
      $display("FAIL inflight_regrant: gnt=%b wr_en=%b data=%h expected 010/00010000/5a", bus.gnt, bus.wr_en, bus.wr_data);
    end
    bus.req[1] = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int         ptr_m = 0;
    logic [2:0] gnt_m = '0;
    logic [7:0] wen_m = '0;
    logic [2:0] wa_m = '0;
    logic [7:0] wd_m = '0;
    bit         granted [NR];
    logic [2:0] elig;
    int         w;
    reset = 1'b1;
    bus.req = '0;
    bus.hold = 1'b0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < NR; k++) granted[k] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // Requesters: hold req through the grant cycle, then drop or re-request.
      for (int k = 0; k < NR; k++) begin
        if (gnt_m[k]) begin
          granted[k] = 1'b1;
        end else if (granted[k]) begin
          granted[k] = 1'b0;
          if ($urandom_range(1, 0) == 1) set_req(k, 1'b1, 3'($urandom), 8'($urandom));
          else bus.req[k] = 1'b0;
        end else if (!bus.req[k] && $urandom_range(9, 0) < 4) begin
          set_req(k, 1'b1, 3'($urandom), 8'($urandom));
        end
      end
      bus.hold = ($urandom_range(4, 0) == 0);
      elig = bus.req & ~gnt_m;
      if (!bus.hold && elig != 3'b000) begin
        w = -1;
        for (int i = 0; i < NR; i++) begin
          if (w < 0 && elig[(ptr_m + i) % NR]) w = (ptr_m + i) % NR;
        end
        gnt_m = 3'(1 << w);
        wa_m  = bus.req_addr[3*w +: 3];
        wd_m  = bus.req_data[DW*w +: DW];
        wen_m = exp_wen(int'(wa_m));
        ptr_m = (w + 1) % NR;
      end else begin
        gnt_m = '0;
        wen_m = '0;
      end
      tick();
      checks++;
      if (bus.gnt !== gnt_m || bus.busy !== (gnt_m != 3'b000)) begin
        errors++;
        $display("FAIL rand_gnt c%0d: gnt=%b busy=%b expected %b/%b", cyc, bus.gnt, bus.busy, gnt_m, gnt_m != 3'b000);
      end
      checks++;
      if (bus.wr_en !== wen_m || bus.wr_addr !== wa_m || bus.wr_data !== wd_m) begin
        errors++;
        $display("FAIL rand_write c%0d: wr_en=%b addr=%0d data=%h expected %b/%0d/%h", cyc, bus.wr_en, bus.wr_addr, bus.wr_data, wen_m, wa_m, wd_m);
      end
    end
    bus.req = '0;
    bus.hold = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    bus.hold = 1'b0;
    bus.req  = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_r0();
    test_reset_inflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the register file's single write port among NUM_REQ requesters (e.g. ALU, memory load, immediate load). It picks one pending request per cycle by round-robin and returns a one-cycle grant. It drives the register file with a registered one-hot write-enable (r0 = MSB), address and data. It sits between the execute/memory stages and the 8-entry register file.

Parameters:
DATA_WIDTH, 8, width of write data
NUM_REQ, 3, number of requesters; legal range 2..4

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  NUM_REQ  per-requester write request; held until granted
req_addr  input  NUM_REQ*3  register index per requester; requester k uses bits [3k+2:3k]
req_data  input  NUM_REQ*DATA_WIDTH  write data per requester; slice k
hold  input  1  suppresses new grants (pipeline stall/flush)
gnt  output  NUM_REQ  one-hot grant, high exactly one cycle per accepted request
wr_en  output  8  one-hot register write enable; bit 7 = r0, bit 0 = r7
wr_addr  output  3  index of register being written
wr_data  output  DATA_WIDTH  data being written
busy  output  1  high in any cycle where gnt is non-zero

Behaviour:
- Reset values (asynchronous, immediate): gnt=0, wr_en=0, wr_addr=0, wr_data=0, round-robin pointer ptr=0, busy=0.
- Eligible set each cycle: req & ~gnt. A requester whose grant is currently high is masked, because it only drops req in the following cycle.
- Arbitration at each rising edge when hold=0 and the eligible set is non-zero:
  - winner = first eligible index searching ptr, ptr+1, … modulo NUM_REQ;
  - registered on the same edge: gnt = one-hot(winner), wr_addr = addr slice, wr_data = data slice, wr_en bit (7 - addr) = 1;
  - ptr = (winner+1) mod NUM_REQ.
- If hold=1 or the eligible set is zero: gnt=0, wr_en=0, and ptr is unchanged. wr_addr and wr_data keep their last values.
- Latency: req sampled high at edge E gives gnt and wr_en high in the cycle after E. Grant and write are coincident. Peak throughput is one write per cycle.
- Requester rule: keep req, addr and data stable until the cycle gnt is seen; deassert or present a new request from the next cycle. The same requester cannot win two consecutive cycles.
- Simultaneous requests: pure round-robin; no fixed priority beyond ptr.
- Reset during an in-flight write: the write is dropped (wr_en cleared immediately). The requester did not complete its handshake and must still have req high; it competes again from ptr=0 after reset release.
- hold rising while gnt is high: the current grant/write completes; there are no new grants from the next edge on.
- Address wrap: indices 0..7 only; no out-of-range case exists.

Optional Feature:
- Macro: REGFILE_R0_ZERO_EN.
- Defined: requests targeting r0 are arbitrated and granted normally (gnt pulses, ptr advances), but wr_en stays 8'b00000000 for that cycle. r0 is hardwired zero.
- Undefined: r0 is writable like any register (wr_en=8'b10000000).

Decomposition:
- Shared package regfile_pkg holds:
  - REG_ADDR_W=3 and REG_COUNT=8;
  - the one-hot mapping constants/function: index i maps to bit 7-i, so r0 is the MSB.
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: eligible vector and ptr.
  - Outputs: winner index and valid.
  - All state stays in regfile_write_arbiter.

Test Plan:
1. reset=1 with req=3'b111 for 5 cycles -> gnt=0, wr_en=0 throughout. On release, first grant is gnt=3'b001.
2. Only req[1], addr=5, data=8'hA5; drop req after gnt -> next cycle gnt=3'b010, wr_en=8'b00000100, wr_addr=5, wr_data=8'hA5. Exactly one grant total.
3. All three req held continuously (each re-asserting after grant) -> gnt sequence 001, 010, 100, 001, 010; wr_en follows each requester's address every cycle.
4. req[2] pending, hold=1 for 4 cycles -> gnt=0, wr_en=0. hold drops at edge E -> gnt=3'b100 in the cycle after E.
5. req[0] addr=0, data=8'h3C -> with REGFILE_R0_ZERO_EN: gnt=3'b001, wr_en=8'h00. Without it: wr_en=8'b10000000, wr_data=8'h3C.
6. Assert reset mid-cycle while gnt=3'b010 -> gnt, wr_en and busy clear immediately, without waiting for an edge. After release, with req[1] still high, gnt=3'b010 is reissued.
